uart_dist_reporter: RTL and testbench

- Periodically formats CHANNELS unsigned binary distance values as ASCII decimal with a fixed decimal point.
- Streams the result one byte at a time to a UART transmitter (UART_send style: start pulse in, done pulse back).
- Parametrised successor of the single-channel fixed-format distance printer. Adds multi-channel framing, generic width/digit count, leading-zero suppression, saturation flagging and a proper byte handshake.
- Sits between the ultrasonic measurement cores and the UART transmitter.

---
 rtl/uart_dist_reporter.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_dist_reporter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dist_reporter.sv
`timescale 1ns/1ps
// uart_dist_reporter: periodically prints CHANNELS binary distance values as
// fixed-point ASCII decimal ("A=123.456,B=0.007\n") to a start/done UART.
module uart_dist_reporter #(
    parameter int CLK_FREQ    = 50000000,
    parameter int REPORT_HZ   = 10,
    parameter int DATA_W      = 19,
    parameter int DIGITS      = 6,
    parameter int FRAC_DIGITS = 3,
    parameter int CHANNELS    = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [CHANNELS-1:0]        ovf,
    output logic                       tick_miss
);

    // Number of decimal digits needed to hold 2^w-1.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int PERIOD       = CLK_FREQ / REPORT_HZ;
    localparam int TCNT_W       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int VAL_DIGITS   = dec_digits(DATA_W);
    localparam int BCD_N        = (VAL_DIGITS > DIGITS) ? VAL_DIGITS : DIGITS;
    localparam int DD_W         = BCD_N * 4 + DATA_W;
    localparam int INT_D        = DIGITS - FRAC_DIGITS;
    // Byte positions within one channel's record.
    localparam int POS_INT_LAST = INT_D + 1;
    localparam int POS_DOT      = INT_D + 2;
    localparam int POS_SEP      = DIGITS + 3;
    localparam int POS_W        = $clog2(POS_SEP + 1);
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam longint unsigned SAT_LIMIT = 64'(10) ** DIGITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        SAT,
        EMIT,
        NEXT
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [TCNT_W-1:0]          tcnt;
    logic                       tick;
    logic                       frame_start;
    logic [CHANNELS*DATA_W-1:0] frame_data;
    logic [CH_W-1:0]            ch;
    logic                       last_ch;
    logic [DATA_W-1:0]          chan_val;
    // BCD digits sit above the binary shift bits in one register so a single
    // left shift moves the next binary MSB into the BCD LSB.
    logic [DD_W-1:0]            dd;
    logic [DD_W-1:0]            dd_adj;
    logic [BIT_W-1:0]           bit_cnt;
    logic                       sat_pend;
    logic [POS_W-1:0]           pos;
    logic                       lead;
    logic                       pend;
    logic [3:0]                 digit;
    logic                       is_int;
    logic                       skip;
    logic                       last_pos;
    logic [7:0]                 byte_d;

    // Report period counter; tick on terminal count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else if (tcnt == TCNT_W'(PERIOD - 1)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Status decode: tick, frame start, last channel, busy.
    always_comb begin
        tick        = (tcnt == TCNT_W'(PERIOD - 1));
        frame_start = tick && enable && (state_q == IDLE);
        last_ch     = (ch == CH_W'(CHANNELS - 1));
        // busy drops as soon as the final separator has been acknowledged.
        busy        = (state_q != IDLE) && !((state_q == NEXT) && last_ch);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (frame_start) state_d = LOAD;
            LOAD: state_d = CONV;
            CONV: if (bit_cnt == BIT_W'(DATA_W - 1)) state_d = SAT;
            SAT:  state_d = EMIT;
            EMIT: if (pend && tx_done && last_pos) state_d = NEXT;
            NEXT: state_d = last_ch ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Select the current channel from the frame snapshot.
    always_comb begin
        chan_val = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ch == CH_W'(i)) chan_val = frame_data[i*DATA_W +: DATA_W];
        end
    end

    // Double-dabble add-3 correction on every BCD nibble >= 5.
    always_comb begin
        dd_adj = dd;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (dd[DATA_W + i*4 +: 4] >= 4'd5) begin
                dd_adj[DATA_W + i*4 +: 4] = dd[DATA_W + i*4 +: 4] + 4'd3;
            end
        end
    end

    // Byte formatter: map the record position to an ASCII character.
    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= FRAC_DIGITS) begin
                if (pos == POS_W'(DIGITS + 1 - i)) digit = dd[DATA_W + i*4 +: 4];
            end else if (pos == POS_W'(DIGITS + 2 - i)) begin
                digit = dd[DATA_W + i*4 +: 4];
            end
        end
        is_int   = (pos >= POS_W'(2)) && (pos <= POS_W'(POS_INT_LAST));
        skip     = is_int && lead && (digit == 4'd0) && (pos != POS_W'(POS_INT_LAST));
        last_pos = (pos == POS_W'(POS_SEP));
        if (pos == '0)                   byte_d = 8'h41 + 8'(ch);
        else if (pos == POS_W'(1))       byte_d = 8'h3D;
        else if (pos == POS_W'(POS_DOT)) byte_d = 8'h2E;
        else if (last_pos)               byte_d = last_ch ? 8'h0A : 8'h2C;
        else                             byte_d = {4'h3, digit};
    end

    // Datapath: snapshot, conversion, saturation, byte handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_data <= '0;
            ch         <= '0;
            dd         <= '0;
            bit_cnt    <= '0;
            sat_pend   <= 1'b0;
            pos        <= '0;
            lead       <= 1'b0;
            pend       <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            ovf        <= '0;
            tick_miss  <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            tick_miss <= tick && enable && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        frame_data <= data_in;
                        ch         <= '0;
                    end
                end
                LOAD: begin
                    dd       <= DD_W'(chan_val);
                    bit_cnt  <= '0;
                    sat_pend <= (64'(chan_val) >= SAT_LIMIT);
                    pos      <= '0;
                    lead     <= 1'b1;
                    pend     <= 1'b0;
                end
                CONV: begin
                    dd      <= dd_adj << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                SAT: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (ch == CH_W'(i)) ovf[i] <= sat_pend;
                    end
                    if (sat_pend) begin
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            dd[DATA_W + i*4 +: 4] <= 4'd9;
                        end
                    end
                end
                EMIT: begin
                    if (!pend) begin
                        if (skip) begin
                            pos <= pos + 1'b1;
                        end else begin
                            tx_data  <= byte_d;
                            tx_start <= 1'b1;
                            pend     <= 1'b1;
                            if (is_int) lead <= 1'b0;
                        end
                    end else if (tx_done) begin
                        pend <= 1'b0;
                        if (!last_pos) pos <= pos + 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_ch) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dist_reporter.sv
`timescale 1ns/1ps
// Directed bench for uart_dist_reporter with a start/done UART model.
// DATA_W is 20 so that 1000000 is representable and saturation is reachable.
module tb_uart_dist_reporter;

    localparam int CH = 2;
    localparam int DW = 20;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enable;
    logic [CH*DW-1:0]  data_in;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic              busy;
    logic [CH-1:0]     ovf;
    logic              tick_miss;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_delay = 20;
    bit         outst = 0;
    int         dcnt = 0;
    logic [7:0] held = '0;
    logic [7:0] rxq[$];
    int         miss_cyc[$];
    int         overlap = 0;
    int         unstable = 0;
    int         start_cnt = 0;
    int         miss_cnt = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    logic       busy_q = 1'b0;
    int         m0, s0, rel, en, n;

    uart_dist_reporter #(
        .CLK_FREQ   (1000),
        .REPORT_HZ  (1),
        .DATA_W     (DW),
        .DIGITS     (6),
        .FRAC_DIGITS(3),
        .CHANNELS   (CH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .data_in  (data_in),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .busy     (busy),
        .ovf      (ovf),
        .tick_miss(tick_miss)
    );

    initial forever #5 clk = ~clk;

    // UART model and monitors, sampled 1 ns after each rising edge.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tx_done = 1'b0;
            if (!rstn) begin
                outst  = 0;
                busy_q = 1'b0;
            end else begin
                if (tx_start) begin
                    start_cnt++;
                    if (outst) begin
                        overlap++;
                    end else begin
                        outst = 1;
                        dcnt  = done_delay;
                        held  = tx_data;
                        rxq.push_back(tx_data);
                    end
                end else if (outst) begin
                    if (tx_data !== held) unstable++;
                    dcnt--;
                    if (dcnt == 0) begin
                        tx_done = 1'b1;
                        outst   = 0;
                    end
                end
                if (tick_miss) begin
                    miss_cnt++;
                    miss_cyc.push_back(cyc);
                end
                if (busy && !busy_q) rise_cyc = cyc;
                if (!busy && busy_q) fall_cyc = cyc;
                busy_q = busy;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int c0, input int c1);
        data_in = {DW'(c1), DW'(c0)};
    endtask

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int k;
        k = 0;
        while (busy !== level && k < budget) begin
            step(1);
            k++;
        end
        if (busy !== level) check(tag, 32'(busy), 32'(level));
    endtask

    task automatic wait_bytes(input int cnt, input int budget, input string tag);
        int k;
        k = 0;
        while (rxq.size() < cnt && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(rxq.size() >= cnt), 32'd1);
    endtask

    task automatic cmp_frame(input string tag, input string exp, input logic [CH-1:0] exp_ovf);
        check({tag, "_len"}, 32'(rxq.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] b;
            b = (i < rxq.size()) ? rxq[i] : 8'h00;
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[i]));
        end
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        rxq.delete();
    endtask

    task automatic run_frame(input string tag, input string exp, input logic [CH-1:0] exp_ovf);
        wait_busy(1'b1, 2500, {tag, "_start"});
        wait_busy(1'b0, 20000, {tag, "_end"});
        cmp_frame(tag, exp, exp_ovf);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_tick_miss"}, 32'(tick_miss), 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        enable  = 1'b0;
        data_in = '0;
        step(5);
        check_reset_vals("rst");
        rstn = 1'b1;

        // Basic frames, saturation, leading-zero suppression.
        enable = 1'b1;
        m0 = miss_cnt;
        set_data(123456, 7);
        run_frame("t1", "A=123.456,B=0.007\n", 2'b00);
        set_data(1000000, 999999);
        run_frame("t2", "A=999.999,B=999.999\n", 2'b01);
        set_data(0, 100000);
        run_frame("t3", "A=0.000,B=100.000\n", 2'b00);
        check("t13_miss", 32'(miss_cnt - m0), 32'd0);

        // Slow UART: frame spans several ticks; data changed mid-frame.
        done_delay = 300;
        set_data(42, 5);
        m0 = miss_cnt;
        miss_cyc.delete();
        wait_busy(1'b1, 2500, "t4_start");
        step(50);
        set_data(999999, 999999);
        wait_busy(1'b0, 20000, "t4_end");
        cmp_frame("t4", "A=0.042,B=0.005\n", 2'b00);
        check("t4_miss_cnt", 32'(miss_cnt - m0), 32'((fall_cyc - rise_cyc) / 1000));
        check("t4_miss_multi", 32'((miss_cnt - m0) >= 2), 32'd1);
        foreach (miss_cyc[i]) check("t4_miss_phase", 32'((miss_cyc[i] - rise_cyc) % 1000), 32'd0);

        // Reset in the middle of EMIT, then a clean restart.
        done_delay = 20;
        set_data(1000000, 250000);
        wait_busy(1'b1, 2500, "t5_start");
        wait_bytes(3, 500, "t5_in_emit");
        check("t5_ovf_pre", 32'(ovf), 32'd1);
        rstn = 1'b0;
        step(3);
        check_reset_vals("t5_rst");
        rxq.delete();
        rstn = 1'b1;
        rel  = cyc;
        wait_busy(1'b1, 1100, "t5_restart");
        check("t5_restart_delay", 32'(rise_cyc - rel), 32'd1000);
        wait_busy(1'b0, 20000, "t5_end");
        cmp_frame("t5", "A=999.999,B=250.000\n", 2'b01);

        // enable gating.
        enable = 1'b0;
        s0 = start_cnt;
        m0 = miss_cnt;
        step(3000);
        check("t6_dis_start", 32'(start_cnt - s0), 32'd0);
        check("t6_dis_miss", 32'(miss_cnt - m0), 32'd0);
        check("t6_dis_busy", 32'(busy), 32'd0);
        set_data(65432, 1);
        enable = 1'b1;
        en = cyc;
        wait_busy(1'b1, 1100, "t6_start");
        check("t6_start_lat", 32'((rise_cyc - en) <= 1000), 32'd1);
        wait_bytes(2, 500, "t6_mid");
        enable = 1'b0;
        wait_busy(1'b0, 20000, "t6_end");
        cmp_frame("t6", "A=65.432,B=0.001\n", 2'b00);
        s0 = start_cnt;
        step(2500);
        check("t6_no_more", 32'(start_cnt - s0), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);

        check("overlap", 32'(overlap), 32'd0);
        check("unstable", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
